// File: rtl/fpnew_classify.sv
`default_nettype none
// ============================================================================
// Module : fpnew_classify
// Brief  : FCLASS decoder with a valid/ready pipeline and a saturating NaN count.
// Macro  : FPNEW_CLASSIFY_NANBOX_EN - a narrow operand that is not NaN-boxed reads as canonical qNaN
// Rev    : 1.0
// ============================================================================
module fpnew_classify #(
  parameter logic [2:0]  FpFormat      = 3'd0,
  parameter int unsigned NUM_PIPE_REGS = 1,
  parameter int unsigned TAG_WIDTH     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [63:0]          operand_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [9:0]           class_o,
  output logic                 is_nan_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic [15:0]          nan_count_o,
  output logic                 busy_o
);

  localparam int unsigned c_exp_bits = (FpFormat == 3'd1) ? 11 :
                                       ((FpFormat == 3'd2) || (FpFormat == 3'd3)) ? 5 : 8;
  localparam int unsigned c_man_bits = (FpFormat == 3'd0) ? 23 :
                                       (FpFormat == 3'd1) ? 52 :
                                       (FpFormat == 3'd2) ? 10 :
                                       (FpFormat == 3'd3) ? 2 : 7;
  localparam int unsigned c_width    = 1 + c_exp_bits + c_man_bits;

  logic                  w_sign;
  logic [c_exp_bits-1:0] w_exp;
  logic [c_man_bits-1:0] w_man;
  logic                  w_boxed;
  logic [9:0]            w_class;
  logic [15:0]           r_nan_count;

  assign w_sign = operand_i[c_width-1];
  assign w_exp  = operand_i[c_width-2:c_man_bits];
  assign w_man  = operand_i[c_man_bits-1:0];

  if (c_width < 64) begin : g_upper
`ifdef FPNEW_CLASSIFY_NANBOX_EN
    assign w_boxed = &operand_i[63:c_width];
`else
    logic w_unused_upper;
    assign w_unused_upper = ^operand_i[63:c_width];
    assign w_boxed        = 1'b1;
`endif
  end else begin : g_full
    assign w_boxed = 1'b1;
  end

  always_comb begin
    w_class = '0;
    if (!w_boxed) begin
      w_class[9] = 1'b1;
    end else if (&w_exp) begin
      if (w_man == '0) begin
        if (w_sign) w_class[0] = 1'b1;
        else        w_class[7] = 1'b1;
      end else if (w_man[c_man_bits-1]) begin
        w_class[9] = 1'b1;
      end else begin
        w_class[8] = 1'b1;
      end
    end else if (w_exp == '0) begin
      if (w_man == '0) begin
        if (w_sign) w_class[3] = 1'b1;
        else        w_class[4] = 1'b1;
      end else begin
        if (w_sign) w_class[2] = 1'b1;
        else        w_class[5] = 1'b1;
      end
    end else begin
      if (w_sign) w_class[1] = 1'b1;
      else        w_class[6] = 1'b1;
    end
  end

  if (NUM_PIPE_REGS == 0) begin : g_comb
    logic w_unused_flush;
    assign w_unused_flush = flush_i;
    assign out_valid_o    = in_valid_i;
    assign in_ready_o     = out_ready_i;
    assign class_o        = w_class;
    assign tag_o          = tag_i;
    assign busy_o         = 1'b0;
  end else begin : g_pipe
    // Index 0 is the decoded input; index i+1 is the output of stage i.
    logic [NUM_PIPE_REGS:0] w_valid_chain;
    logic [9:0]             w_class_chain [NUM_PIPE_REGS+1];
    logic [TAG_WIDTH-1:0]   w_tag_chain   [NUM_PIPE_REGS+1];
    logic [NUM_PIPE_REGS:0] w_ready;

    assign w_valid_chain[0]       = in_valid_i;
    assign w_class_chain[0]       = w_class;
    assign w_tag_chain[0]         = tag_i;
    assign w_ready[NUM_PIPE_REGS] = out_ready_i;

    for (genvar i = 0; i < NUM_PIPE_REGS; i++) begin : g_stage
      logic                 r_valid;
      logic [9:0]           r_class;
      logic [TAG_WIDTH-1:0] r_tag;

      // Flattened form of !valid[i] | ready[i+1]: some stage at or after i has room.
      assign w_ready[i] = out_ready_i | ~(&w_valid_chain[NUM_PIPE_REGS:i+1]);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_valid <= 1'b0;
          r_class <= '0;
          r_tag   <= '0;
        end else if (flush_i) begin
          r_valid <= 1'b0;
        end else if (w_ready[i]) begin
          r_valid <= w_valid_chain[i];
          if (w_valid_chain[i]) begin
            r_class <= w_class_chain[i];
            r_tag   <= w_tag_chain[i];
          end
        end
      end

      assign w_valid_chain[i+1] = r_valid;
      assign w_class_chain[i+1] = r_class;
      assign w_tag_chain[i+1]   = r_tag;
    end

    assign in_ready_o  = w_ready[0];
    assign out_valid_o = w_valid_chain[NUM_PIPE_REGS];
    assign class_o     = w_class_chain[NUM_PIPE_REGS];
    assign tag_o       = w_tag_chain[NUM_PIPE_REGS];
    assign busy_o      = |w_valid_chain[NUM_PIPE_REGS:1];
  end

  assign is_nan_o = class_o[9] | class_o[8];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_nan_count <= '0;
    end else if (out_valid_o && out_ready_i && is_nan_o && (r_nan_count != 16'hFFFF)) begin
      r_nan_count <= r_nan_count + 16'd1;
    end
  end

  assign nan_count_o = r_nan_count;

endmodule
`default_nettype wire
